// File: rtl/adc_sample_avg.sv
// Sliding-window mean over the last 2^LOG2_DEPTH accepted ADC samples.
// Define ADC_AVG_ROUND_EN to round half up instead of truncating the mean.
module adc_sample_avg #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              filled
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0]   CNT_ONE  = (LOG2_DEPTH+1)'(1);
    localparam logic [LOG2_DEPTH:0]   CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
`ifdef ADC_AVG_ROUND_EN
    localparam logic [SUM_W-1:0]      HALF     = SUM_W'(DEPTH/2);
`endif

    typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

    state_t                  state;
    logic [DATA_W-1:0]       buf_q [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr;
    logic [SUM_W-1:0]        sum;
    logic [LOG2_DEPTH:0]     fill_cnt;
    logic [SUM_W-1:0]        sum_next;
    logic [LOG2_DEPTH:0]     cnt_next;
    logic [DATA_W-1:0]       avg_next;

    // Evicted entry is subtracted back out; buffer starts zeroed so the
    // fill phase needs no special case.
    always_comb begin
        sum_next = sum + SUM_W'(sample_in) - SUM_W'(buf_q[wr_ptr]);
`ifdef ADC_AVG_ROUND_EN
        avg_next = DATA_W'((sum_next + HALF) >> LOG2_DEPTH);
`else
        avg_next = DATA_W'(sum_next >> LOG2_DEPTH);
`endif
        cnt_next = fill_cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            state     <= EMPTY;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            filled    <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
                wr_ptr   <= '0;
                sum      <= '0;
                fill_cnt <= '0;
                state    <= EMPTY;
                filled   <= 1'b0;
            end else if (sample_valid) begin
                buf_q[wr_ptr] <= sample_in;
                wr_ptr        <= wr_ptr + PTR_ONE;
                sum           <= sum_next;
                case (state)
                    EMPTY, FILL: begin
                        fill_cnt <= cnt_next;
                        if (cnt_next == CNT_FULL) begin
                            state     <= RUN;
                            filled    <= 1'b1;
                            avg_valid <= 1'b1;
                            avg_out   <= avg_next;
                        end else begin
                            state <= FILL;
                        end
                    end
                    RUN: begin
                        avg_valid <= 1'b1;
                        avg_out   <= avg_next;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_avg.sv
// Randomized + directed bench for adc_sample_avg against a queue-based window model.
module tb_adc_sample_avg;
    localparam int DW    = 16;
    localparam int LD    = 3;
    localparam int DEPTH = 1 << LD;
`ifdef ADC_AVG_ROUND_EN
    localparam int ROUND = 1;
`else
    localparam int ROUND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] avg_out;
    logic          avg_valid;
    logic          filled;

    adc_sample_avg #(.DATA_W(DW), .LOG2_DEPTH(LD)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .clear(clear), .avg_out(avg_out), .avg_valid(avg_valid), .filled(filled)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: the window is simply the most recent DEPTH accepted samples
    // since the last reset/clear; the mean is computed from that list.
    int            win[$];
    logic          exp_valid = 1'b0;
    logic          exp_filled = 1'b0;
    logic [DW-1:0] exp_avg = '0;

    function automatic logic [DW-1:0] win_mean();
        longint s = 0;
        foreach (win[i]) s += win[i];
        return DW'((s + ROUND * (DEPTH / 2)) / DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win.delete();
            exp_valid  <= 1'b0;
            exp_filled <= 1'b0;
            exp_avg    <= '0;
        end else if (clear) begin
            win.delete();
            exp_valid  <= 1'b0;
            exp_filled <= 1'b0;
        end else if (sample_valid) begin
            win.push_back(int'(sample_in));
            if (win.size() > DEPTH) void'(win.pop_front());
            exp_filled <= (win.size() == DEPTH);
            exp_valid  <= (win.size() == DEPTH);
            if (win.size() == DEPTH) exp_avg <= win_mean();
        end else begin
            exp_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("avg_valid", 32'(avg_valid), 32'(exp_valid));
            chk("filled", 32'(filled), 32'(exp_filled));
            chk("avg_out", 32'(avg_out), 32'(exp_avg));
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic c);
        @(negedge clk);
        sample_valid = v;
        sample_in    = d;
        clear        = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, DW'($urandom), 1'b0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        drive(1'b1, d, 1'b0);
        drive(1'b0, DW'($urandom), 1'b0);
    endtask

    task automatic do_clear();
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_avg_out", 32'(avg_out), 0);
        chk("rst_valid", 32'(avg_valid), 0);
        chk("rst_filled", 32'(filled), 0);

        // Fill with 1000s at random gaps
        for (int i = 0; i < DEPTH; i++) begin
            send(16'd1000);
            if (i < DEPTH - 1) begin
                chk("fill_no_valid", 32'(avg_valid), 0);
                idle($urandom_range(0, 3));
            end
        end
        chk("fill_valid", 32'(avg_valid), 1);
        chk("fill_avg", 32'(avg_out), 1000);
        chk("fill_filled", 32'(filled), 1);

        send(16'd1800);
        chk("step_avg", 32'(avg_out), 1100);
        for (int i = 0; i < DEPTH; i++) begin
            send(16'd1800);
            idle($urandom_range(0, 2));
        end
        chk("wrap_avg", 32'(avg_out), 1800);

        do_clear();
        for (int i = 0; i < DEPTH - 1; i++) send(16'd0);
        send(16'd4);
        chk("round_avg", 32'(avg_out), 32'(ROUND));

        do_clear();
        for (int i = 0; i < DEPTH; i++) send(16'hFFFF);
        chk("max_avg", 32'(avg_out), 32'hFFFF);
        chk("max_valid", 32'(avg_valid), 1);

        // Clear wins over a simultaneous sample in RUN
        drive(1'b1, 16'd5000, 1'b1);
        drive(1'b0, '0, 1'b0);
        chk("clr_valid", 32'(avg_valid), 0);
        chk("clr_filled", 32'(filled), 0);
        chk("clr_hold", 32'(avg_out), 32'hFFFF);
        for (int i = 0; i < DEPTH - 1; i++) send(16'd2000);
        chk("clr7_filled", 32'(filled), 0);
        chk("clr7_hold", 32'(avg_out), 32'hFFFF);
        send(16'd2000);
        chk("clr8_valid", 32'(avg_valid), 1);
        chk("clr8_avg", 32'(avg_out), 2000);

        // Async reset mid-fill
        do_clear();
        for (int i = 0; i < 5; i++) send(16'd300);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_avg", 32'(avg_out), 0);
        chk("arst_valid", 32'(avg_valid), 0);
        chk("arst_filled", 32'(filled), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(16'd500);
        chk("post_rst_avg", 32'(avg_out), 500);
        chk("post_rst_valid", 32'(avg_valid), 1);

        // Random traffic: back-to-back samples, gaps, occasional clears
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [DW-1:0] d;
            r = $urandom_range(0, 39);
            d = (r % 3 == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
            if (r == 0) drive(1'b0, d, 1'b1);
            else if (r == 1) drive(1'b1, d, 1'b1);
            else if (r < 26) drive(1'b1, d, 1'b0);
            else drive(1'b0, d, 1'b0);
        end
        drive(1'b0, '0, 1'b0);
        idle(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adc_sample_avg.md
ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of raw ADC sample and averaged output.
REQ-002 SHALL have parameter LOG2_DEPTH, default 3: window depth DEPTH = 2^LOG2_DEPTH samples, legal range 1..6.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port sample_in  input  DATA_W: raw unsigned ADC code.
REQ-006 SHALL have port sample_valid  input  1: one-cycle strobe; sample_in accepted when high.
REQ-007 SHALL have port clear  input  1: synchronous flush of window, active high.
REQ-008 SHALL have port avg_out  output  DATA_W: unsigned sliding-window mean, registered; feeds distance lookup adc_data.
REQ-009 SHALL have port avg_valid  output  1: one-cycle pulse marking a new avg_out.
REQ-010 SHALL have port filled  output  1: high once DEPTH samples held since last reset/clear.

Function
REQ-011 SHALL hold a circular buffer of DEPTH DATA_W-bit entries, write pointer wr_ptr (LOG2_DEPTH bits), running sum of DATA_W+LOG2_DEPTH bits, fill counter of LOG2_DEPTH+1 bits.
REQ-012 SHALL, on accepted sample: sum <= sum + sample_in - buf[wr_ptr]; buf[wr_ptr] <= sample_in; wr_ptr <= wr_ptr+1 modulo DEPTH (7 -> 0 wraps silently).
REQ-013 SHALL implement states EMPTY, FILL, RUN: EMPTY->FILL on first accepted sample; FILL->RUN on the accepted sample making the count DEPTH; RUN persists; any state ->EMPTY on clear.
REQ-014 SHALL drive filled high exactly when state is RUN (registered, same edge as state).
REQ-015 SHALL pulse avg_valid for one cycle in the cycle after each accepted sample that leaves state in RUN, including the DEPTH-th sample; latency 1 clock from sample_valid to avg_valid.
REQ-016 SHALL keep avg_valid low for samples accepted in EMPTY/FILL (not completing fill).
REQ-017 SHALL compute avg_out = updated sum >> LOG2_DEPTH and register it only when avg_valid is set; otherwise hold.
REQ-018 SHALL ignore sample_in when sample_valid is low; idle gaps of any length do not alter state.
REQ-019 SHALL, on clear: zero all buffer entries, sum, wr_ptr, fill count; state EMPTY; avg_valid low next cycle; avg_out holds last value.
REQ-020 SHALL give clear priority over simultaneous sample_valid; that sample is dropped.
REQ-021 SHALL never overflow sum: max DEPTH*(2^DATA_W-1) fits DATA_W+LOG2_DEPTH bits.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear buffer, sum, wr_ptr, fill count, avg_out=0, avg_valid=0, filled=0, state EMPTY.
REQ-023 SHALL, on reset mid-FILL or mid-RUN, discard all samples; DEPTH new samples required before next avg_valid.

Configuration
REQ-024 SHALL support macro ADC_AVG_ROUND_EN.
REQ-025 SHALL, with ADC_AVG_ROUND_EN defined, compute avg_out = (sum + DEPTH/2) >> LOG2_DEPTH (round half up); result never exceeds 2^DATA_W-1.
REQ-026 SHALL, without ADC_AVG_ROUND_EN, truncate (floor) as in REQ-017.

Verification (DATA_W=16, LOG2_DEPTH=3)
REQ-027 SHALL cover: reset, 8 samples of 1000 at random gaps -> avg_valid only after 8th, avg_out=1000, filled=1 same cycle.
REQ-028 SHALL cover: window of 1000s, then one sample 1800 -> next avg_out=1100; 8 more 1800s -> 1800 with wr_ptr wrapping.
REQ-029 SHALL cover: seven 0s then one 4 -> avg_out=0 without ADC_AVG_ROUND_EN, 1 with it.
REQ-030 SHALL cover: 8 samples 0xFFFF -> avg_out=0xFFFF in both configurations, no wrap.
REQ-031 SHALL cover: clear with sample_valid high in RUN -> no avg_valid, filled=0, avg_out held, next 7 samples give no avg_valid, 8th does.
REQ-032 SHALL cover: rst_n low after 5 samples -> all outputs 0 immediately; 8 fresh samples of 500 -> avg_out=500.
